// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Releases CHANNELS active-low reset outputs one after another once the chip
// reset has been released. The deassertion of n_rst is synchronised through a
// two-flop chain, while its assertion acts asynchronously. After the internal
// release, the block waits HOLD_CYCLES clocks before freeing channel 0. It then
// frees each following channel STEP_CYCLES clocks after the previous one.
// A free-running divider produces a one-cycle clk_en strobe every DIV clocks.
//
// Ports
//   clk           sole clock, all logic on the rising edge
//   n_rst         asynchronous active-low reset
//   soft_rst_req  synchronous request to restart the release sequence
//   n_rst_out     per-channel active-low resets, bit 0 released first
//   seq_done      high once every channel is released
//   busy          inverse of seq_done
//   clk_en        one-cycle strobe every DIV clocks after release
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 5,
  parameter int STEP_CYCLES = 2,
  parameter int DIV         = 5
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                soft_rst_req,
  output logic [CHANNELS-1:0] n_rst_out,
  output logic                seq_done,
  output logic                busy,
  output logic                clk_en
);

  localparam int MAX_CYC = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {HOLD, STEP, DONE} state_t;

  logic                rst_sync_p0;
  logic                rst_sync_p1;
  logic                released;
  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [CHANNELS-1:0] out_nxt;
  logic                done_nxt;
  logic [DIV_W-1:0]    div_cnt;

  // Stage p0/p1: reset deassertion synchroniser
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rst_sync_p0 <= 1'b0;
      rst_sync_p1 <= 1'b0;
    end else begin
      rst_sync_p0 <= 1'b1;
      rst_sync_p1 <= rst_sync_p0;
    end
  end

  assign released = rst_sync_p1;

  // Sequencer state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= HOLD;
      cnt       <= '0;
      n_rst_out <= '0;
      seq_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      n_rst_out <= out_nxt;
      seq_done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = n_rst_out;
    done_nxt  = seq_done;
    if (released) begin
      if (soft_rst_req) begin
        // A held request keeps the counter parked at zero; counting restarts
        // on the first edge that samples the request low.
        state_nxt = HOLD;
        cnt_nxt   = '0;
        out_nxt   = '0;
        done_nxt  = 1'b0;
      end else begin
        unique case (state)
          HOLD: begin
            if (cnt == HOLD_LAST) begin
              out_nxt    = '0;
              out_nxt[0] = 1'b1;
              cnt_nxt    = '0;
              if (CHANNELS == 1) begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
              end else begin
                state_nxt = STEP;
              end
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
          STEP: begin
            if (cnt == STEP_LAST) begin
              // Shifting a one in from the bottom keeps the release order
              // monotonic by construction.
              out_nxt = (n_rst_out << 1) | CHANNELS'(1);
              cnt_nxt = '0;
              if (out_nxt[CHANNELS-1]) begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
              end
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
          DONE:    state_nxt = DONE;
          default: state_nxt = HOLD;
        endcase
      end
    end
  end

  // Free-running strobe divider, independent of soft restarts
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt <= '0;
    end else if (released) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  assign clk_en = released && (div_cnt == DIV_LAST);
  assign busy   = ~seq_done;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  typedef struct packed {
    logic [31:0] out;
    logic        done;
    logic        busy;
    logic        en;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_rst_a = 1'b0;
  logic       n_rst_b = 1'b0;
  logic       soft_a = 1'b0;
  logic       soft_b = 1'b0;
  logic [3:0] out_a;
  logic [0:0] out_b;
  logic       done_a, busy_a, en_a;
  logic       done_b, busy_b, en_b;

  int n_total = 0;
  int n_bad   = 0;
  int e_a     = -1;
  int base_a  = 2;
  int e_b     = -1;
  int base_b  = 2;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t xa, xb;

  reset_sequencer #(.CHANNELS(4), .HOLD_CYCLES(5), .STEP_CYCLES(2), .DIV(5)) dut_a (
    .clk(clk), .n_rst(n_rst_a), .soft_rst_req(soft_a),
    .n_rst_out(out_a), .seq_done(done_a), .busy(busy_a), .clk_en(en_a)
  );

  reset_sequencer #(.CHANNELS(1), .HOLD_CYCLES(1), .STEP_CYCLES(2), .DIV(1)) dut_b (
    .clk(clk), .n_rst(n_rst_b), .soft_rst_req(soft_b),
    .n_rst_out(out_b), .seq_done(done_b), .busy(busy_b), .clk_en(en_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Timing model: e = edge index since E0, base = first edge the hold
  // counter counts; channel k rises at base + hold - 1 + k*step.
  function automatic exp_t model(input int e, input int base, input int ch,
                                 input int hold, input int step, input int dv);
    exp_t r;
    int   dc;
    r.out = '0;
    for (int k = 0; k < ch; k++) begin
      if (e >= base + hold - 1 + k * step) r.out[k] = 1'b1;
    end
    r.done = r.out[ch-1];
    r.busy = !r.done;
    dc     = (e >= 2) ? ((e - 1) % dv) : 0;
    r.en   = (e >= 1) && (dc == dv - 1);
    return r;
  endfunction

  always @(negedge n_rst_a) begin
    e_a    = -1;
    base_a = 2;
  end

  always @(posedge clk) begin
    if (n_rst_a) begin
      e_a++;
      if (e_a >= 2 && soft_a) base_a = e_a + 1;
      q_a.push_back(model(e_a, base_a, 4, 5, 2, 5));
    end
    if (n_rst_b) begin
      e_b++;
      if (e_b >= 2 && soft_b) base_b = e_b + 1;
      q_b.push_back(model(e_b, base_b, 1, 1, 2, 1));
    end
  end

  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      xa = q_a.pop_front();
      chk("a_out",  32'(out_a),  xa.out);
      chk("a_done", 32'(done_a), 32'(xa.done));
      chk("a_busy", 32'(busy_a), 32'(xa.busy));
      chk("a_clken", 32'(en_a),  32'(xa.en));
      chk("a_mono", 32'(out_a[3:1] & ~out_a[2:0]), 32'd0);
    end
    if (q_b.size() > 0) begin
      xb = q_b.pop_front();
      chk("b_out",  32'(out_b),  xb.out);
      chk("b_done", 32'(done_b), 32'(xb.done));
      chk("b_busy", 32'(busy_b), 32'(xb.busy));
      chk("b_clken", 32'(en_b),  32'(xb.en));
    end
  end

  // Advance to just after the falling edge that follows edge E(n) of DUT A.
  task automatic goto(input int n);
    for (int i = 0; i < 2000 && e_a != n; i++) @(negedge clk);
    chk("goto_edge", 32'(e_a), 32'(n));
    #2;
  endtask

  task automatic pulse_a();
    n_rst_a = 1'b0;
    #1;
    chk("async_out",  32'(out_a),  32'd0);
    chk("async_done", 32'(done_a), 32'd0);
    chk("async_busy", 32'(busy_a), 32'd1);
    chk("async_clken", 32'(en_a),  32'd0);
    #1;
    n_rst_a = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_a_out",  32'(out_a),  32'd0);
    chk("rst_a_done", 32'(done_a), 32'd0);
    chk("rst_a_busy", 32'(busy_a), 32'd1);
    chk("rst_a_clken", 32'(en_a),  32'd0);
    chk("rst_b_out",  32'(out_b),  32'd0);
    chk("rst_b_clken", 32'(en_b),  32'd0);
    #1;
    n_rst_a = 1'b1;
    n_rst_b = 1'b1;

    // One-cycle soft restart sampled at E20
    goto(19);
    soft_a = 1'b1;
    soft_b = 1'b1;
    goto(20);
    soft_a = 1'b0;
    soft_b = 1'b0;

    // Soft restart held for ten edges, E45..E54
    goto(44);
    soft_a = 1'b1;
    goto(54);
    soft_a = 1'b0;

    // Hard reset while in DONE, then again mid-STEP after E8
    goto(70);
    pulse_a();
    goto(8);
    pulse_a();
    goto(20);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of sequenced reset outputs (legal range 1..32).
REQ-002 SHALL have parameter HOLD_CYCLES, default 5, clk cycles from internal release to channel 0 release (>=1).
REQ-003 SHALL have parameter STEP_CYCLES, default 2, clk cycles between consecutive channel releases (>=1).
REQ-004 SHALL have parameter DIV, default 5, clk_en strobe period in clk cycles (>=1).
REQ-005 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port soft_rst_req  input  1  synchronous request to restart the sequence.
REQ-008 SHALL have port n_rst_out  output  CHANNELS  per-channel active-low reset, bit 0 released first.
REQ-009 SHALL have port seq_done  output  1  high once all channels are released.
REQ-010 SHALL have port busy  output  1  equals !seq_done.
REQ-011 SHALL have port clk_en  output  1  one-cycle strobe every DIV cycles.

Function
REQ-012 SHALL synchronise n_rst deassertion through a 2-flop chain; assertion acts asynchronously.
- E0 = first rising edge with n_rst high.
- Internal release takes effect after E1.
- E2 = first released edge.
REQ-013 SHALL implement states HOLD, STEP, DONE, with a counter sized $clog2(max(HOLD_CYCLES,STEP_CYCLES)+1).
REQ-014 In HOLD, SHALL increment the counter each released edge.
- Edge where counter == HOLD_CYCLES-1: set n_rst_out[0]=1, counter=0, go STEP.
- If CHANNELS==1: go DONE instead of STEP.
REQ-015 In STEP, SHALL increment the counter each edge.
- Edge where counter == STEP_CYCLES-1: release the next channel, counter=0.
- Release of channel CHANNELS-1: go DONE.
REQ-016 Channel k SHALL rise at edge E(1+HOLD_CYCLES+k*STEP_CYCLES).
REQ-017 seq_done SHALL rise on the same edge as n_rst_out[CHANNELS-1].
REQ-018 Once released, a channel SHALL stay high until n_rst low or a soft restart.
REQ-019 soft_rst_req sampled high on a released edge in any state SHALL, on that edge: clear all n_rst_out, clear seq_done, go HOLD, counter=0.
REQ-020 While soft_rst_req stays high, SHALL hold HOLD with counter 0.
- Restart counting begins on the first edge sampling it low.
- Channel 0 releases HOLD_CYCLES edges after the request edge Ex, i.e. at Ex+HOLD_CYCLES for a one-cycle pulse.
REQ-021 soft_rst_req SHALL be ignored while the internal reset is asserted.
REQ-022 SHALL have a free-running divider counter, 0..DIV-1.
- Increments from E2 and wraps DIV-1 -> 0.
- clk_en = released && (cnt == DIV-1).
- With DIV==1, clk_en is constant 1 after release.
REQ-023 The divider and clk_en SHALL be unaffected by soft_rst_req.
REQ-024 SHALL drive no output combinationally from soft_rst_req.
REQ-025 SHALL guarantee monotonic release order: bit k never high while bit k-1 is low.

Reset
REQ-026 n_rst low SHALL immediately (asynchronously) force all outputs low:
- n_rst_out = 0
- seq_done = 0
- busy = 1
- clk_en = 0
REQ-027 n_rst low SHALL also force state HOLD, both counters 0, and sync chain 0.
REQ-028 n_rst assertion mid-sequence or in DONE SHALL abort and fully restart per REQ-012 on deassertion.

Verification
REQ-029 Defaults, n_rst released before E0:
- n_rst_out[0] rises at E6, [1] at E8, [2] at E10, [3] at E12.
- seq_done=1 from E12; busy low from E12.
REQ-030 Defaults, one-cycle soft_rst_req at E20:
- n_rst_out=0 and seq_done=0 after E20.
- Bit 0 at E25, bit 3 and seq_done at E31.
- clk_en period stays 5 throughout, uninterrupted.
REQ-031 soft_rst_req held high E20..E29:
- Outputs stay 0 throughout.
- Bit 0 rises at E34 (first low sample at E30, then 5 HOLD edges ending at E34).
REQ-032 n_rst pulsed low between E8 and E9 (mid-STEP):
- All outputs 0 asynchronously, not waiting for an edge.
- Sequence restarts with the new E0 at the first edge after deassertion.
REQ-033 CHANNELS=1, HOLD_CYCLES=1, DIV=1:
- n_rst_out[0] and seq_done rise at E2.
- clk_en constant 1 from after E1.
- A checker asserts REQ-025 throughout.
